// File: rtl/cam_pkg.sv
// Shared widths, sizes and writer state encoding for the camera frame writer.
package cam_pkg;
  localparam int CAM_ADDR_W = 17;
  localparam int CAM_WORD_W = 32;
  localparam int CAM_PIX_W  = 8;
  localparam int CAM_BE_W   = CAM_WORD_W / CAM_PIX_W;
  localparam int RAM_WORDS  = 87500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } cam_wr_state_t;

  // Byte enables for a word whose highest filled lane is 'lane'.
  function automatic logic [CAM_BE_W-1:0] lane_be(input logic [1:0] lane);
    return CAM_BE_W'((5'd2 << lane) - 5'd1);
  endfunction
endpackage

// File: rtl/cam_word_fifo.sv
// Synchronous show-ahead FIFO; a push while full succeeds only if a pop frees the slot.
module cam_word_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CAM_BE_W + CAM_WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         one
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level;
  logic          do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign one     = (level == (AW+1)'(1));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/cam_frame_writer.sv
// Packs 8-bit camera pixels four per word and writes one frame to RAM over Avalon-MM.
// State table:  IDLE - waiting for start | ARMED - waiting for sof | CAPTURE - packing pixels
//               DRAIN - flushing FIFO | DONE - frame written, done held
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter logic [CAM_ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                    FRAME_PIXELS = 76800,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [CAM_PIX_W-1:0]  pix_data,
  output logic [CAM_ADDR_W-1:0] avm_address,
  output logic                  avm_write,
  output logic [CAM_WORD_W-1:0] avm_writedata,
  output logic [CAM_BE_W-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int ENT_W = CAM_ADDR_W + CAM_BE_W + CAM_WORD_W;

  cam_wr_state_t           state_q, state_d;
  logic [CNT_W-1:0]        count_q;
  logic [1:0]              lane_q;
  logic [23:0]             pack_q;
  logic [CAM_ADDR_W-1:0]   addr_q;
  logic                    done_q, overflow_q;

  logic                    arm, pix_take, pix_last, word_push, fifo_pop, dropped;
  logic                    fifo_full, fifo_empty, fifo_one;
  logic [CAM_WORD_W-1:0]   word_data, head_data;
  logic [CAM_BE_W-1:0]     word_be, head_be;
  logic [CAM_ADDR_W-1:0]   head_addr;

  assign arm       = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign pix_take  = pix_valid & (((state_q == ST_ARMED) & pix_sof) | (state_q == ST_CAPTURE));
  assign pix_last  = (count_q == CNT_W'(FRAME_PIXELS - 1));
  assign word_push = pix_take & ((lane_q == 2'd3) | pix_last);
  assign fifo_pop  = avm_write & ~avm_waitrequest;
  assign dropped   = word_push & fifo_full & ~fifo_pop;

  // Lanes above the current pixel stay zero, which also zero-fills partial words.
  always_comb begin
    word_data = '0;
    case (lane_q)
      2'd0:    word_data = {24'h0, pix_data};
      2'd1:    word_data = {16'h0, pix_data, pack_q[7:0]};
      2'd2:    word_data = {8'h0, pix_data, pack_q[15:0]};
      default: word_data = {pix_data, pack_q};
    endcase
    word_be = lane_be(lane_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_ARMED;
      ST_ARMED:         if (pix_take) state_d = pix_last ? ST_DRAIN : ST_CAPTURE;
      ST_CAPTURE:       if (pix_take && pix_last) state_d = ST_DRAIN;
      ST_DRAIN:         if (fifo_empty || (fifo_pop && fifo_one)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == ST_ARMED) | (state_q == ST_CAPTURE) | (state_q == ST_DRAIN);
    avm_write      = ~fifo_empty;
    avm_address    = fifo_empty ? BASE_ADDR : head_addr;
    avm_writedata  = fifo_empty ? '0 : head_data;
    avm_byteenable = fifo_empty ? '0 : head_be;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      addr_q     <= BASE_ADDR;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (arm) begin
      count_q    <= '0;
      lane_q     <= '0;
      addr_q     <= BASE_ADDR;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (pix_take) begin
        count_q <= count_q + CNT_W'(1);
        lane_q  <= lane_q + 2'd1;
        pack_q  <= word_data[23:0];
      end
      if (word_push) addr_q <= addr_q + CAM_ADDR_W'(1);
      if (dropped) overflow_q <= 1'b1;
      if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) done_q <= 1'b1;
    end
  end

  assign done     = done_q;
  assign overflow = overflow_q;

  // Each entry carries its own target address so a dropped word leaves a gap in RAM.
  cam_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (word_push),
    .pop   (fifo_pop),
    .wdata ({addr_q, word_be, word_data}),
    .rdata ({head_addr, head_be, head_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .one   (fifo_one)
  );
endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized bench for cam_frame_writer against a frame-level reference model.
module tb_cam_frame_writer;
  localparam logic [16:0] BASE  = 17'd100;
  localparam int          NPIX  = 22;
  localparam int          DEPTH = 4;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        avm_waitrequest = 1'b0;
  logic [16:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        busy, done, overflow;

  int n_checks = 0;
  int n_errors = 0;

  cam_frame_writer #(
    .BASE_ADDR    (BASE),
    .FRAME_PIXELS (NPIX),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pix_valid       (pix_valid),
    .pix_sof         (pix_sof),
    .pix_data        (pix_data),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: modes 0 idle, 1 armed, 2 capture, 3 drain, 4 done.
  int          m_mode = 0;
  int          m_cnt = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  logic [7:0]  m_buf [4];
  exp_t        q [$];
  logic [31:0] ram [256];
  logic [3:0]  ram_be [256];
  int          wr_cnt = 0;

  always @(negedge clk) begin : model
    exp_t e;
    int   lanes;
    bit   take;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_done = 0; m_ovf = 0;
      q.delete();
      check_val("rst_write", avm_write, 0);
      check_val("rst_busy", busy, 0);
    end else begin
      check_val("write", avm_write, q.size() != 0);
      if (avm_write && q.size() > 0) begin
        check_val("addr", avm_address, q[0].addr);
        check_val("data", avm_writedata, q[0].data);
        check_val("be", avm_byteenable, q[0].be);
      end
      check_val("busy", busy, (m_mode >= 1 && m_mode <= 3));
      check_val("done", done, m_done);
      check_val("overflow", overflow, m_ovf);
      if (avm_write && !avm_waitrequest) begin
        ram[avm_address[7:0]]    = avm_writedata;
        ram_be[avm_address[7:0]] = avm_byteenable;
        wr_cnt++;
      end
      if (q.size() > 0 && !avm_waitrequest) q.delete(0);
      take = 0;
      case (m_mode)
        0, 4: if (start) begin m_mode = 1; m_cnt = 0; m_done = 0; m_ovf = 0; end
        1: take = pix_valid && pix_sof;
        2: take = pix_valid;
        3: if (q.size() == 0) begin m_mode = 4; m_done = 1; end
        default: ;
      endcase
      if (take) begin
        m_buf[m_cnt % 4] = pix_data;
        m_cnt++;
        if (m_cnt % 4 == 0 || m_cnt == NPIX) begin
          lanes  = (m_cnt - 1) % 4 + 1;
          e.addr = BASE + 17'((m_cnt - 1) / 4);
          e.data = '0;
          for (int i = 0; i < lanes; i++) e.data[8*i +: 8] = m_buf[i];
          e.be   = 4'((1 << lanes) - 1);
          if (q.size() == DEPTH) m_ovf = 1;
          else q.push_back(e);
        end
        m_mode = (m_cnt == NPIX) ? 3 : 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends n valid pixels, the first carrying sof; optional stall window and stray start.
  task automatic feed(input int n, input int vpct, input int wpct, input int stall,
                      input bit incr, input logic [7:0] first, input int start_at);
    int sent = 0;
    int c = 0;
    while (sent < n) begin
      pix_valid = ($urandom_range(99) < vpct);
      pix_sof   = pix_valid && (sent == 0 || $urandom_range(9) == 0);
      pix_data  = incr ? 8'(sent + 1) : (sent == 0 ? first : 8'($urandom));
      avm_waitrequest = (c < stall) ? 1'b1 : ($urandom_range(99) < wpct);
      start = (c == start_at);
      if (pix_valid) sent++;
      tick();
      c++;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int wpct);
    for (int i = 0; i < 500 && !done; i++) begin
      avm_waitrequest = ($urandom_range(99) < wpct);
      tick();
    end
    avm_waitrequest = 1'b0;
    check_val("done_reached", done, 1);
    tick();
  endtask

  initial begin
    int base_cnt;
    #1;
    check_val("rst_addr", avm_address, BASE);
    check_val("rst_wdata", avm_writedata, 0);
    check_val("rst_be", avm_byteenable, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ovf", overflow, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Sequential pixels, no stalls: full words then a 2-byte tail.
    pulse_start();
    base_cnt = wr_cnt;
    feed(NPIX, 100, 0, 0, 1, 8'h00, -1);
    wait_done(0);
    check_val("w0", ram[100], 32'h04030201);
    check_val("w1", ram[101], 32'h08070605);
    check_val("w1_be", ram_be[101], 4'hF);
    check_val("tail", ram[105], 32'h00001615);
    check_val("tail_be", ram_be[105], 4'b0011);
    check_val("n_words", wr_cnt - base_cnt, 6);
    check_val("no_ovf", overflow, 0);

    // Pixels before sof are ignored; the sof pixel is pixel 0.
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      pix_valid = $urandom_range(1);
      pix_sof   = 1'b0;
      pix_data  = 8'($urandom);
      tick();
    end
    check_val("armed_busy", busy, 1);
    feed(NPIX, 80, 20, 0, 0, 8'h11, -1);
    wait_done(20);
    check_val("sof_byte0", ram[100][7:0], 8'h11);

    // Long stall with continuous pixels overflows the FIFO.
    pulse_start();
    base_cnt = wr_cnt;
    feed(NPIX, 100, 0, 20, 0, 8'h5A, -1);
    wait_done(0);
    check_val("stall_ovf", overflow, 1);
    check_val("stall_words", wr_cnt - base_cnt, 5);

    // Reset in the middle of capture.
    pulse_start();
    feed(9, 100, 0, 0, 0, 8'h33, -1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_write", avm_write, 0);
    check_val("mid_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    feed(NPIX, 70, 30, 0, 1, 8'h00, -1);
    wait_done(30);
    check_val("after_rst_w0", ram[100], 32'h04030201);

    // start pulsed during capture is ignored.
    pulse_start();
    base_cnt = wr_cnt;
    feed(NPIX, 100, 0, 0, 0, 8'h77, 8);
    wait_done(0);
    check_val("stray_start_words", wr_cnt - base_cnt, 6);

    // Random frames with random valid gaps and backpressure.
    for (int f = 0; f < 6; f++) begin
      pulse_start();
      feed(NPIX, 40 + 10 * f, 15 * f, 0, 0, 8'($urandom), -1);
      wait_done(15 * f);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
